canvas_port_arbiter: RTL and testbench

Shares write/read port A of the 336×256 canvas RAM between a single-pixel CPU requester and a rectangle-fill engine. The engine clears or paints clipped rectangles, one pixel per granted cycle. The block sits between the CPU bus bridge and canvas port A; port B stays dedicated to scan-out. The RAM address is {col[8:0], row[7:0]}, and each RAM word is {alpha[1:0], color[7:0]}.

---
 rtl/canvas_pkg.sv | 23 ++
 rtl/canvas_fill_walker.sv | 77 +++++++
 rtl/canvas_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_canvas_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared canvas geometry, address packing and fill state encoding
package canvas_pkg;

    localparam int CANVAS_COLS = 336;
    localparam int CANVAS_ROWS = 256;
    localparam int COL_W       = 9;
    localparam int ROW_W       = 8;
    localparam int ADDR_W      = 17;
    localparam int PIX_W       = 10;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_SETUP,
        FS_RUN,
        FS_DONE
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COL_W-1:0] col,
                                                     input logic [ROW_W-1:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/canvas_fill_walker.sv
// rtl/canvas_fill_walker.sv - clipped rectangle raster walker (clip, col/row counters, last flag)
module canvas_fill_walker
    import canvas_pkg::*;
#(
    parameter int COLS = CANVAS_COLS,
    parameter int ROWS = CANVAS_ROWS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [COL_W-1:0] i_col0,
    input  logic [ROW_W-1:0] i_row0,
    input  logic [8:0]       i_w,
    input  logic [8:0]       i_h,
    input  logic             i_advance,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last,
    output logic             o_empty
);

    logic [COL_W-1:0] r_col0;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row0;
    logic [ROW_W-1:0] r_row;
    logic [8:0]       r_w;
    logic [8:0]       r_h;

    logic [9:0] w_room_c;
    logic [9:0] w_room_r;
    logic [9:0] w_cw;
    logic [9:0] w_ch;
    logic [9:0] w_last_col;
    logic [9:0] w_last_row;

    // Clip is derived from the geometry latched at start; the room terms are
    // meaningless when col0 is off-canvas, which o_empty already covers.
    always_comb begin
        w_room_c   = 10'(COLS) - {1'b0, r_col0};
        w_room_r   = 10'(ROWS) - {2'b0, r_row0};
        w_cw       = ({1'b0, r_w} < w_room_c) ? {1'b0, r_w} : w_room_c;
        w_ch       = ({1'b0, r_h} < w_room_r) ? {1'b0, r_h} : w_room_r;
        w_last_col = {1'b0, r_col0} + w_cw - 10'd1;
        w_last_row = {2'b0, r_row0} + w_ch - 10'd1;
    end

    assign o_empty = ({1'b0, r_col0} >= 10'(COLS)) || (w_cw == 10'd0) || (w_ch == 10'd0);
    assign o_last  = ({1'b0, r_col} == w_last_col) && ({2'b0, r_row} == w_last_row);
    assign o_col   = r_col;
    assign o_row   = r_row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col0 <= '0;
            r_row0 <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (i_start) begin
            r_col0 <= i_col0;
            r_row0 <= i_row0;
            r_w    <= i_w;
            r_h    <= i_h;
            r_col  <= i_col0;
            r_row  <= i_row0;
        end else if (i_advance) begin
            if ({1'b0, r_col} == w_last_col) begin
                r_col <= r_col0;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end
    end

endmodule

// File: rtl/canvas_port_arbiter.sv
// rtl/canvas_port_arbiter.sv - shares canvas RAM port A between CPU pixel access and the fill engine
module canvas_port_arbiter
    import canvas_pkg::*;
#(
    parameter int COLS = CANVAS_COLS,
    parameter int ROWS = CANVAS_ROWS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [COL_W-1:0]  cpu_col,
    input  logic [ROW_W-1:0]  cpu_row,
    input  logic [PIX_W-1:0]  cpu_wdata,
    output logic              cpu_ack,
    output logic [PIX_W-1:0]  cpu_rdata,
    input  logic              fill_start,
    input  logic [COL_W-1:0]  fill_col0,
    input  logic [ROW_W-1:0]  fill_row0,
    input  logic [8:0]        fill_w,
    input  logic [8:0]        fill_h,
    input  logic [PIX_W-1:0]  fill_data,
    input  logic              fill_abort,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_di,
    input  logic [PIX_W-1:0]  ram_do
);

    fill_state_t       r_state;
    logic              r_fin;
    logic              r_last_cpu;
    logic              r_rd_p1;
    logic              r_rd_p2;
    logic [PIX_W-1:0]  r_fill_data;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [PIX_W-1:0]  r_ram_di;
    logic              r_cpu_ack;
    logic [PIX_W-1:0]  r_cpu_rdata;
    logic              r_fill_busy;
    logic              r_fill_done;

    logic              w_start;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_last;
    logic              w_empty;
    logic              w_cpu_want;
    logic              w_fill_want;
    logic              w_contend;
    logic              w_cpu_grant;
    logic              w_fill_grant;

    assign w_start = (r_state == FS_IDLE) && fill_start;

    canvas_fill_walker #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_walker (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_col0    (fill_col0),
        .i_row0    (fill_row0),
        .i_w       (fill_w),
        .i_h       (fill_h),
        .i_advance (w_fill_grant),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_last    (w_last),
        .o_empty   (w_empty)
    );

    // The fill already wants the port at the SETUP edge so its first write
    // lands right after SETUP; the ack cycle never starts a CPU transaction.
    always_comb begin
        w_cpu_want   = cpu_req && !r_cpu_ack && !r_rd_p1 && !r_rd_p2;
        w_fill_want  = !fill_abort &&
                       (((r_state == FS_SETUP) && !w_empty) ||
                        ((r_state == FS_RUN) && !r_fin));
        w_contend    = w_cpu_want && w_fill_want;
        w_cpu_grant  = w_cpu_want && (!w_fill_want || !r_last_cpu);
        w_fill_grant = w_fill_want && !w_cpu_grant;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FS_IDLE;
            r_fin       <= 1'b0;
            r_last_cpu  <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_rd_p2     <= 1'b0;
            r_fill_data <= '0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_di    <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_ram_we    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_fill_done <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_rd_p2     <= r_rd_p1;

            if (r_rd_p2) begin
                r_cpu_ack   <= 1'b1;
                r_cpu_rdata <= ram_do;
            end

            if (w_contend) begin
                r_last_cpu <= w_cpu_grant;
            end

            if (w_cpu_grant) begin
                r_ram_we   <= cpu_we;
                r_ram_addr <= pack_addr(cpu_col, cpu_row);
                if (cpu_we) begin
                    r_ram_di  <= cpu_wdata;
                    r_cpu_ack <= 1'b1;
                end else begin
                    r_rd_p1   <= 1'b1;
                end
            end else if (w_fill_grant) begin
                r_ram_we   <= 1'b1;
                r_ram_addr <= pack_addr(w_col, w_row);
                r_ram_di   <= r_fill_data;
            end

            case (r_state)
                FS_IDLE: begin
                    if (fill_start) begin
                        r_state     <= FS_SETUP;
                        r_fill_busy <= 1'b1;
                        r_fill_data <= fill_data;
                        r_fin       <= 1'b0;
                    end
                end
                FS_SETUP: begin
                    if (fill_abort) begin
                        r_state     <= FS_IDLE;
                        r_fill_busy <= 1'b0;
                    end else if (w_empty) begin
                        r_state     <= FS_DONE;
                        r_fill_done <= 1'b1;
                    end else begin
                        r_state <= FS_RUN;
                        r_fin   <= w_fill_grant && w_last;
                    end
                end
                FS_RUN: begin
                    if (fill_abort) begin
                        r_state     <= FS_IDLE;
                        r_fill_busy <= 1'b0;
                    end else if (r_fin) begin
                        r_state     <= FS_DONE;
                        r_fill_done <= 1'b1;
                    end else if (w_fill_grant && w_last) begin
                        r_fin <= 1'b1;
                    end
                end
                FS_DONE: begin
                    r_state     <= FS_IDLE;
                    r_fill_busy <= 1'b0;
                end
                default: begin
                    r_state     <= FS_IDLE;
                    r_fill_busy <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_di    = r_ram_di;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// tb/tb_canvas_port_arbiter.sv - directed self-checking bench for canvas_port_arbiter
module tb_canvas_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [8:0]  cpu_col = '0;
    logic [7:0]  cpu_row = '0;
    logic [9:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [9:0]  cpu_rdata;
    logic        fill_start = 1'b0;
    logic [8:0]  fill_col0 = '0;
    logic [7:0]  fill_row0 = '0;
    logic [8:0]  fill_w = '0;
    logic [8:0]  fill_h = '0;
    logic [9:0]  fill_data = '0;
    logic        fill_abort = 1'b0;
    logic        fill_busy;
    logic        fill_done;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [9:0]  ram_di;
    logic [9:0]  ram_do = '0;

    logic [9:0]  mem [0:131071];

    int n_cmp = 0;
    int n_err = 0;

    canvas_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_col    (cpu_col),
        .cpu_row    (cpu_row),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_col0  (fill_col0),
        .fill_row0  (fill_row0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_data  (fill_data),
        .fill_abort (fill_abort),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_do     (ram_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        ram_do <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".ram_we"},    32'(ram_we),    32'd0);
        check({tag, ".ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, ".ram_di"},    32'(ram_di),    32'd0);
        check({tag, ".cpu_ack"},   32'(cpu_ack),   32'd0);
        check({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, ".fill_busy"}, 32'(fill_busy), 32'd0);
        check({tag, ".fill_done"}, 32'(fill_done), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts a fill at the current negedge and watches ncyc cycles; write k is
    // expected at col c0 + k%ecw, row r0 + k/ecw with value d.
    task automatic do_fill(input logic [8:0] c0, input logic [7:0] r0,
                           input logic [8:0] w, input logic [8:0] h, input logic [9:0] d,
                           input int ecw, input int ech, input bit abort_too, input int ncyc,
                           output int nwr, output int first_wr, output int done_at,
                           output int ndone, output int nbad, output int busy_after);
        int ea;
        fill_col0  = c0;
        fill_row0  = r0;
        fill_w     = w;
        fill_h     = h;
        fill_data  = d;
        fill_start = 1'b1;
        fill_abort = abort_too;
        nwr = 0; first_wr = -1; done_at = -1; ndone = 0; nbad = 0; busy_after = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            fill_start = 1'b0;
            fill_abort = 1'b0;
            if (ram_we === 1'b1) begin
                if (first_wr < 0) first_wr = i;
                if (ecw == 0 || nwr >= ecw * ech) begin
                    nbad++;
                end else begin
                    ea = (int'(c0) + nwr % ecw) * 256 + int'(r0) + nwr / ecw;
                    if (ram_addr !== ea[16:0] || ram_di !== d) nbad++;
                end
                nwr++;
            end
            if (fill_done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (done_at >= 0 && i == done_at + 1) busy_after = int'(fill_busy);
        end
    endtask

    initial begin
        int nwr, first_wr, done_at, ndone, nbad, busy_after, cnt;
        int own [8];
        int fidx;
        own = '{1, 0, 1, 0, 0, 1, 0, 1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("reset");

        // 3x2 fill, no CPU traffic
        do_fill(9'd10, 8'd20, 9'd3, 9'd2, 10'h2A5, 3, 2, 1'b0, 12,
                nwr, first_wr, done_at, ndone, nbad, busy_after);
        check("f3x2.writes", nwr, 6);
        check("f3x2.first", first_wr, 2);
        check("f3x2.done_at", done_at, 8);
        check("f3x2.ndone", ndone, 1);
        check("f3x2.order", nbad, 0);
        check("f3x2.busy_after", busy_after, 0);

        // clipped fill; start wins over a simultaneous idle abort
        do_fill(9'd330, 8'd250, 9'd20, 9'd20, 10'h0C3, 6, 6, 1'b1, 45,
                nwr, first_wr, done_at, ndone, nbad, busy_after);
        check("clip.writes", nwr, 36);
        check("clip.order", nbad, 0);
        check("clip.done_at", done_at, 38);
        check("clip.ndone", ndone, 1);

        do_fill(9'd340, 8'd5, 9'd5, 9'd5, 10'h001, 0, 0, 1'b0, 6,
                nwr, first_wr, done_at, ndone, nbad, busy_after);
        check("offcol.writes", nwr, 0);
        check("offcol.done_at", done_at, 2);
        check("offcol.busy_after", busy_after, 0);

        do_fill(9'd5, 8'd5, 9'd0, 9'd5, 10'h001, 0, 0, 1'b0, 6,
                nwr, first_wr, done_at, ndone, nbad, busy_after);
        check("w0.writes", nwr, 0);
        check("w0.done_at", done_at, 2);

        // CPU write then read of (5,7)
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_col = 9'd5; cpu_row = 8'd7; cpu_wdata = 10'h155;
        @(negedge clk);
        check("cw.we", 32'(ram_we), 32'd1);
        check("cw.addr", 32'(ram_addr), 32'h507);
        check("cw.di", 32'(ram_di), 32'h155);
        check("cw.ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("cw.ack_low", 32'(cpu_ack), 32'd0);
        check("cw.addr_hold", 32'(ram_addr), 32'h507);
        cpu_req = 1'b1; cpu_we = 1'b0;
        @(negedge clk);
        check("cr.we", 32'(ram_we), 32'd0);
        check("cr.addr", 32'(ram_addr), 32'h507);
        check("cr.ack1", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        check("cr.ack2", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        check("cr.ack3", 32'(cpu_ack), 32'd1);
        check("cr.rdata", 32'(cpu_rdata), 32'h155);
        cpu_req = 1'b0;
        @(negedge clk);
        check("cr.ack_low", 32'(cpu_ack), 32'd0);
        check("cr.rdata_hold", 32'(cpu_rdata), 32'h155);

        // contention: continuous CPU writes against a 4x1 fill right after reset
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_col = 9'd100; cpu_row = 8'd100; cpu_wdata = 10'h0AA;
        fill_col0 = 9'd0; fill_row0 = 8'd0; fill_w = 9'd4; fill_h = 9'd1; fill_data = 10'h3FF;
        fill_start = 1'b1;
        fidx = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            fill_start = 1'b0;
            check($sformatf("mix.we%0d", i), 32'(ram_we), 32'd1);
            check($sformatf("mix.ack%0d", i), 32'(cpu_ack), 32'(own[i]));
            check($sformatf("mix.done%0d", i), 32'(fill_done), (i == 7) ? 32'd1 : 32'd0);
            if (own[i] == 1) begin
                check($sformatf("mix.cdi%0d", i), 32'(ram_di), 32'h0AA);
            end else begin
                check($sformatf("mix.fdi%0d", i), 32'(ram_di), 32'h3FF);
                check($sformatf("mix.faddr%0d", i), 32'(ram_addr), 32'(fidx * 256));
                fidx++;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
        check("mix.busy_after", 32'(fill_busy), 32'd0);

        // abort after two of ten writes
        fill_col0 = 9'd50; fill_row0 = 8'd60; fill_w = 9'd10; fill_h = 9'd1; fill_data = 10'h111;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        check("ab.setup_busy", 32'(fill_busy), 32'd1);
        @(negedge clk);
        check("ab.w0", 32'(ram_addr), 32'(50 * 256 + 60));
        @(negedge clk);
        check("ab.w1", 32'(ram_addr), 32'(51 * 256 + 60));
        fill_abort = 1'b1;
        @(negedge clk);
        fill_abort = 1'b0;
        check("ab.we", 32'(ram_we), 32'd0);
        check("ab.busy", 32'(fill_busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ram_we !== 1'b0 || fill_done !== 1'b0) cnt++;
        end
        check("ab.quiet", cnt, 0);

        // reset during a fill with a CPU read outstanding
        fill_col0 = 9'd0; fill_row0 = 8'd0; fill_w = 9'd100; fill_h = 9'd1; fill_data = 10'h0F0;
        fill_start = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_col = 9'd5; cpu_row = 8'd7;
        @(negedge clk);
        fill_start = 1'b0;
        check("rs.read_issue", 32'(ram_addr), 32'h507);
        @(negedge clk);
        check("rs.fill_we", 32'(ram_we), 32'd1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("rs.async");
        @(negedge clk);
        cpu_req = 1'b0;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b0) cnt++;
        end
        check("rs.quiet", cnt, 0);

        do_fill(9'd10, 8'd20, 9'd3, 9'd2, 10'h2A5, 3, 2, 1'b0, 12,
                nwr, first_wr, done_at, ndone, nbad, busy_after);
        check("rs.refill_writes", nwr, 6);
        check("rs.refill_order", nbad, 0);
        check("rs.refill_done", done_at, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
